iomem_arbiter: RTL and testbench

Two-master arbiter for the SoC peripheral bus (`iomem_*`). The CPU (master 0) and a DMA/bridge engine (master 1) share the single iomem slave bus that feeds the GPIO and template peripherals. The block serves one transaction at a time and grants round-robin. A watchdog completes any access the slave never acknowledges, so an unmapped address cannot hang a master.

---
 rtl/iomem_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_iomem_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/iomem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : iomem_arbiter
// Function : Two-master round-robin arbiter for the iomem peripheral bus.
//            Handles one transaction at a time. A watchdog completes any
//            access the slave never acknowledges, so a master cannot hang.
// Revision : 1.0 - initial release
// ============================================================================
module iomem_arbiter #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  // master 0 (CPU)
  input  logic        m0_valid,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  // master 1 (DMA / bridge)
  input  logic        m1_valid,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  // shared slave bus
  output logic        s_valid,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  // status
  input  logic        err_clr,
  output logic        timeout_err,
  output logic        last_grant
);

  // Counter value seen in the final cycle before the watchdog fires.
  localparam logic [15:0] C_CNT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q,       state_d;
  logic [15:0] cnt_q,         cnt_d;
  logic        s_valid_q,     s_valid_d;
  logic [3:0]  s_wstrb_q,     s_wstrb_d;
  logic [31:0] s_addr_q,      s_addr_d;
  logic [31:0] s_wdata_q,     s_wdata_d;
  logic        m0_ready_q,    m0_ready_d;
  logic        m1_ready_q,    m1_ready_d;
  logic [31:0] m0_rdata_q,    m0_rdata_d;
  logic [31:0] m1_rdata_q,    m1_rdata_d;
  logic        timeout_err_q, timeout_err_d;
  logic        last_grant_q,  last_grant_d;

  // Winner of this IDLE cycle: a lone requester, or on contention the master
  // that was not served last.
  logic win;
  assign win = (m0_valid && m1_valid) ? ~last_grant_q : m1_valid;

  // Next-state and output computation for the IDLE/BUSY/DONE sequencer.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    s_valid_d     = s_valid_q;
    s_wstrb_d     = s_wstrb_q;
    s_addr_d      = s_addr_q;
    s_wdata_d     = s_wdata_q;
    m0_ready_d    = 1'b0;
    m1_ready_d    = 1'b0;
    m0_rdata_d    = m0_rdata_q;
    m1_rdata_d    = m1_rdata_q;
    last_grant_d  = last_grant_q;
    // Clear is applied first so that a timeout in the same cycle overrides it.
    timeout_err_d = err_clr ? 1'b0 : timeout_err_q;

    case (state_q)
      ST_IDLE: begin
        if (m0_valid || m1_valid) begin
          s_valid_d    = 1'b1;
          s_wstrb_d    = win ? m1_wstrb : m0_wstrb;
          s_addr_d     = win ? m1_addr  : m0_addr;
          s_wdata_d    = win ? m1_wdata : m0_wdata;
          last_grant_d = win;
          cnt_d        = 16'd0;
          state_d      = ST_BUSY;
        end
      end

      ST_BUSY: begin
        cnt_d = cnt_q + 16'd1;
        if (s_ready) begin
          // A slave response always beats the watchdog.
          s_valid_d = 1'b0;
          state_d   = ST_DONE;
          if (last_grant_q) begin
            m1_ready_d = 1'b1;
            m1_rdata_d = s_rdata;
          end else begin
            m0_ready_d = 1'b1;
            m0_rdata_d = s_rdata;
          end
        end else if (cnt_q == C_CNT_LAST) begin
          s_valid_d     = 1'b0;
          timeout_err_d = 1'b1;
          state_d       = ST_DONE;
          if (last_grant_q) begin
            m1_ready_d = 1'b1;
            m1_rdata_d = ERR_DATA;
          end else begin
            m0_ready_d = 1'b1;
            m0_rdata_d = ERR_DATA;
          end
        end
      end

      ST_DONE: begin
        // Single cycle for the master to see ready and drop its request;
        // any other request is deliberately not sampled here.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 16'd0;
      s_valid_q     <= 1'b0;
      s_wstrb_q     <= 4'd0;
      s_addr_q      <= 32'd0;
      s_wdata_q     <= 32'd0;
      m0_ready_q    <= 1'b0;
      m1_ready_q    <= 1'b0;
      m0_rdata_q    <= 32'd0;
      m1_rdata_q    <= 32'd0;
      timeout_err_q <= 1'b0;
      last_grant_q  <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      s_valid_q     <= s_valid_d;
      s_wstrb_q     <= s_wstrb_d;
      s_addr_q      <= s_addr_d;
      s_wdata_q     <= s_wdata_d;
      m0_ready_q    <= m0_ready_d;
      m1_ready_q    <= m1_ready_d;
      m0_rdata_q    <= m0_rdata_d;
      m1_rdata_q    <= m1_rdata_d;
      timeout_err_q <= timeout_err_d;
      last_grant_q  <= last_grant_d;
    end
  end

  assign s_valid     = s_valid_q;
  assign s_wstrb     = s_wstrb_q;
  assign s_addr      = s_addr_q;
  assign s_wdata     = s_wdata_q;
  assign m0_ready    = m0_ready_q;
  assign m1_ready    = m1_ready_q;
  assign m0_rdata    = m0_rdata_q;
  assign m1_rdata    = m1_rdata_q;
  assign timeout_err = timeout_err_q;
  assign last_grant  = last_grant_q;

endmodule
`default_nettype wire

// File: tb/tb_iomem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_iomem_arbiter
// Function : Self-checking bench for iomem_arbiter: directed scenarios then
//            randomized transactions against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iomem_arbiter;

  localparam int          TO = 8;
  localparam logic [31:0] ED = 32'hDEAD_BEEF;

  logic        clk;
  logic        reset;
  logic        m0_valid, m1_valid;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid;
  logic [3:0]  s_wstrb;
  logic [31:0] s_addr, s_wdata;
  logic        s_ready;
  logic [31:0] s_rdata;
  logic        err_clr;
  logic        timeout_err;
  logic        last_grant;

  iomem_arbiter #(.TIMEOUT(TO), .ERR_DATA(ED)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_wstrb(m0_wstrb), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_wstrb(s_wstrb), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .err_clr(err_clr), .timeout_err(timeout_err), .last_grant(last_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Transaction-level model state.
  logic        mdl_last;
  logic [31:0] mdl_rd [2];
  logic        mdl_terr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transaction. lat = BUSY cycle on which the slave answers;
  // lat > TO means the slave stays silent.
  task automatic txn(input logic v0, input logic v1,
                     input logic [3:0] ws0, input logic [3:0] ws1,
                     input logic [31:0] a0, input logic [31:0] a1,
                     input logic [31:0] d0, input logic [31:0] d1,
                     input int lat, input logic [31:0] sd, input logic clr);
    logic        w;
    logic        to;
    logic [31:0] ea, edat, erd;
    logic [3:0]  ews;
    int          hv;
    w    = (v0 && v1) ? ~mdl_last : v1;
    ea   = w ? a1 : a0;
    edat = w ? d1 : d0;
    ews  = w ? ws1 : ws0;
    to   = (lat > TO);
    erd  = to ? ED : sd;
    hv   = 0;

    @(negedge clk);
    m0_valid = v0; m0_wstrb = ws0; m0_addr = a0; m0_wdata = d0;
    m1_valid = v1; m1_wstrb = ws1; m1_addr = a1; m1_wdata = d1;
    err_clr = clr; s_ready = 1'b0;
    @(posedge clk); #1;
    if (s_valid) hv++;
    chk("grant_addr",  s_addr, ea);
    chk("grant_wdata", s_wdata, edat);
    chk("grant_wstrb", 32'(s_wstrb), 32'(ews));
    chk("last_grant",  32'(last_grant), 32'(w));
    chk("grant_rdy",   32'({m0_ready, m1_ready}), 32'd0);

    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      s_ready = (k == lat);
      s_rdata = (k == lat) ? sd : $urandom;
      @(posedge clk); #1;
      if (s_valid) hv++;
      if (k == lat || k == TO) break;
      chk("busy_addr", s_addr, ea);
      chk("busy_rdy",  32'({m0_ready, m1_ready}), 32'd0);
    end

    chk("svalid_cycles", 32'(hv), to ? 32'(TO) : 32'(lat));
    chk("win_ready",  32'(w ? m1_ready : m0_ready), 32'd1);
    chk("lose_ready", 32'(w ? m0_ready : m1_ready), 32'd0);
    chk("win_rdata",  w ? m1_rdata : m0_rdata, erd);
    chk("lose_rdata", w ? m0_rdata : m1_rdata, mdl_rd[~w]);
    mdl_rd[w] = erd;
    mdl_terr  = to ? 1'b1 : (clr ? 1'b0 : mdl_terr);
    mdl_last  = w;
    chk("terr_done", 32'(timeout_err), 32'(mdl_terr));

    @(negedge clk);
    m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0; err_clr = 1'b0;
    @(posedge clk); #1;
    chk("idle_svalid", 32'(s_valid), 32'd0);
    chk("idle_rdy",    32'({m0_ready, m1_ready}), 32'd0);
    chk("terr_idle",   32'(timeout_err), 32'(mdl_terr));
  endtask

  initial begin
    logic rv0, rv1, rc;
    reset = 1'b1; err_clr = 1'b0; s_ready = 1'b0; s_rdata = 32'd0;
    m0_valid = 1'b0; m0_wstrb = 4'd0; m0_addr = 32'd0; m0_wdata = 32'd0;
    m1_valid = 1'b0; m1_wstrb = 4'd0; m1_addr = 32'd0; m1_wdata = 32'd0;
    mdl_last = 1'b1; mdl_rd[0] = 32'd0; mdl_rd[1] = 32'd0; mdl_terr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_svalid", 32'(s_valid), 32'd0);
    chk("rst_saddr",  s_addr, 32'd0);
    chk("rst_rdy",    32'({m0_ready, m1_ready}), 32'd0);
    chk("rst_rdata0", m0_rdata, 32'd0);
    chk("rst_terr",   32'(timeout_err), 32'd0);
    chk("rst_lastg",  32'(last_grant), 32'd1);
    @(negedge clk); reset = 1'b0;

    // Single read from m0, zero-wait slave.
    txn(1'b1, 1'b0, 4'h0, 4'h0, 32'h0000_0100, 32'h0, 32'h0, 32'h0, 1, 32'h0000_0001, 1'b0);
    // Write from m1.
    txn(1'b0, 1'b1, 4'h0, 4'hF, 32'h0, 32'h0300_0000, 32'h0, 32'hA5A5_0F0F, 2, 32'h1234_5678, 1'b0);
    // Contention: must alternate starting with m0.
    for (int i = 0; i < 4; i++)
      txn(1'b1, 1'b1, 4'h0, 4'h3, 32'h100 + 32'(i), 32'h200 + 32'(i), 32'h0, $urandom,
          $urandom_range(1, 3), $urandom, 1'b0);
    // Silent slave: watchdog completion, sticky error.
    txn(1'b1, 1'b0, 4'h0, 4'h0, 32'h0400_0000, 32'h0, 32'h0, 32'h0, TO + 5, 32'h0, 1'b0);
    txn(1'b0, 1'b1, 4'h0, 4'h0, 32'h0, 32'h0400_0004, 32'h0, 32'h0, 2, 32'hCAFE_0001, 1'b0);
    @(negedge clk); err_clr = 1'b1;
    @(posedge clk); #1;
    mdl_terr = 1'b0;
    chk("err_clr", 32'(timeout_err), 32'd0);
    @(negedge clk); err_clr = 1'b0;
    // Slave answers on the very cycle the watchdog would fire.
    txn(1'b1, 1'b0, 4'h0, 4'h0, 32'h10, 32'h0, 32'h0, 32'h0, TO, 32'h5555_AAAA, 1'b0);
    // Timeout while err_clr is held: set wins.
    txn(1'b0, 1'b1, 4'h0, 4'h0, 32'h0, 32'h20, 32'h0, 32'h0, TO + 1, 32'h0, 1'b1);

    // Reset in the middle of a BUSY access.
    @(negedge clk); m0_valid = 1'b1; m0_addr = 32'h0000_0ABC; m0_wstrb = 4'h0;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk); reset = 1'b1; m0_valid = 1'b0;
    @(posedge clk); #1;
    chk("mrst_svalid", 32'(s_valid), 32'd0);
    chk("mrst_rdy",    32'({m0_ready, m1_ready}), 32'd0);
    chk("mrst_terr",   32'(timeout_err), 32'd0);
    mdl_last = 1'b1; mdl_rd[0] = 32'd0; mdl_rd[1] = 32'd0; mdl_terr = 1'b0;
    @(negedge clk); reset = 1'b0;
    txn(1'b0, 1'b1, 4'h0, 4'h1, 32'h0, 32'h0300_0010, 32'h0, 32'h77, 1, 32'h0BAD_F00D, 1'b0);

    // Randomized transactions.
    for (int i = 0; i < 40; i++) begin
      rv0 = 1'($urandom_range(0, 1));
      rv1 = rv0 ? 1'($urandom_range(0, 1)) : 1'b1;
      rc  = ($urandom_range(0, 5) == 0);
      txn(rv0, rv1, 4'($urandom), 4'($urandom), $urandom, $urandom, $urandom, $urandom,
          $urandom_range(1, TO + 2), $urandom, rc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
